// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port round-robin front end for the cache model with hit/miss latency and per-port stats
module cache_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int HIT_LAT  = 1,
    parameter int MISS_LAT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_valid,
    input  logic             m1_valid,
    output logic             m0_ready,
    output logic             m1_ready,
    input  logic [AW-1:0]    m0_addr,
    input  logic [AW-1:0]    m1_addr,
    input  logic [DW-1:0]    m0_wdata,
    input  logic [DW-1:0]    m1_wdata,
    input  logic             m0_we,
    input  logic             m1_we,
    output logic             m0_rvalid,
    output logic             m1_rvalid,
    output logic [DW-1:0]    m0_rdata,
    output logic [DW-1:0]    m1_rdata,
    output logic             m0_hit,
    output logic             m1_hit,
    output logic             c_req,
    output logic [AW-1:0]    c_addr,
    output logic [DW-1:0]    c_wdata,
    output logic             c_we,
    input  logic [DW-1:0]    c_rdata,
    input  logic             c_hit,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] req_cnt0,
    output logic [CNT_W-1:0] req_cnt1,
    output logic [CNT_W-1:0] hit_cnt0,
    output logic [CNT_W-1:0] hit_cnt1
);

    localparam int LAT_MAX = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);
    localparam logic [LAT_W-1:0] HIT_LOAD  = LAT_W'(HIT_LAT - 1);
    localparam logic [LAT_W-1:0] MISS_LOAD = LAT_W'((MISS_LAT > 0) ? MISS_LAT - 1 : 0);
    localparam bit NO_STALL = (MISS_LAT == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STALL,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic             r_port;
    logic [LAT_W-1:0] r_lat;
    logic [DW-1:0]    r_rdata;
    logic             r_hit;
    logic [AW-1:0]    r_c_addr;
    logic [DW-1:0]    r_c_wdata;
    logic             r_c_we;
    logic [CNT_W-1:0] r_req_cnt0;
    logic [CNT_W-1:0] r_req_cnt1;
    logic [CNT_W-1:0] r_hit_cnt0;
    logic [CNT_W-1:0] r_hit_cnt1;
    logic             w_grant;
    logic             w_accept;
    logic             w_lat_done;
    logic             w_resp_hit;

    // r_last = 1 means m1 was granted last, so m0 wins the next tie
    assign w_grant    = m1_valid & (~m0_valid | ~r_last);
    assign w_accept   = (r_state == IDLE) & (m0_valid | m1_valid);
    assign w_lat_done = (r_lat == '0);
    assign w_resp_hit = (r_state == RESP) & r_hit;

    assign m0_ready  = w_accept & ~w_grant;
    assign m1_ready  = w_accept & w_grant;
    assign c_req     = (r_state == ISSUE);
    assign c_addr    = r_c_addr;
    assign c_wdata   = r_c_wdata;
    assign c_we      = r_c_we;
    assign m0_rvalid = (r_state == RESP) & ~r_port;
    assign m1_rvalid = (r_state == RESP) & r_port;
    assign m0_rdata  = m0_rvalid ? r_rdata : '0;
    assign m1_rdata  = m1_rvalid ? r_rdata : '0;
    assign m0_hit    = m0_rvalid & r_hit;
    assign m1_hit    = m1_rvalid & r_hit;
    assign req_cnt0  = r_req_cnt0;
    assign req_cnt1  = r_req_cnt1;
    assign hit_cnt0  = r_hit_cnt0;
    assign hit_cnt1  = r_hit_cnt1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = ISSUE;
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (w_lat_done) begin
                    w_next = (c_hit || NO_STALL) ? RESP : STALL;
                end
            end
            STALL: if (w_lat_done) w_next = RESP;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_lat     <= '0;
            r_rdata   <= '0;
            r_hit     <= 1'b0;
            r_c_addr  <= '0;
            r_c_wdata <= '0;
            r_c_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port    <= w_grant;
                        r_last    <= w_grant;
                        r_c_addr  <= w_grant ? m1_addr  : m0_addr;
                        r_c_wdata <= w_grant ? m1_wdata : m0_wdata;
                        r_c_we    <= w_grant ? m1_we    : m0_we;
                    end
                end
                ISSUE: r_lat <= HIT_LOAD;
                WAIT: begin
                    // the stall count is preloaded here so STALL can start counting immediately
                    if (w_lat_done) begin
                        r_rdata <= c_rdata;
                        r_hit   <= c_hit;
                        r_lat   <= MISS_LOAD;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                STALL: if (!w_lat_done) r_lat <= r_lat - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            r_req_cnt0 <= '0;
            r_req_cnt1 <= '0;
            r_hit_cnt0 <= '0;
            r_hit_cnt1 <= '0;
        end else begin
            if (m0_ready && r_req_cnt0 != CNT_MAX) r_req_cnt0 <= r_req_cnt0 + 1'b1;
            if (m1_ready && r_req_cnt1 != CNT_MAX) r_req_cnt1 <= r_req_cnt1 + 1'b1;
            if (w_resp_hit && !r_port && r_hit_cnt0 != CNT_MAX) r_hit_cnt0 <= r_hit_cnt0 + 1'b1;
            if (w_resp_hit && r_port && r_hit_cnt1 != CNT_MAX) r_hit_cnt1 <= r_hit_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed bench for cache_port_arbiter (default build and HIT_LAT=3/MISS_LAT=0/CNT_W=2 build)
module tb_cache_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_m0_valid, a_m1_valid, a_m0_ready, a_m1_ready;
    logic [31:0] a_m0_addr, a_m1_addr, a_m0_wdata, a_m1_wdata;
    logic        a_m0_we, a_m1_we, a_m0_rvalid, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_m0_hit, a_m1_hit, a_c_req, a_c_we, a_c_hit, a_clr;
    logic [31:0] a_c_addr, a_c_wdata, a_c_rdata;
    logic [15:0] a_req_cnt0, a_req_cnt1, a_hit_cnt0, a_hit_cnt1;

    logic        b_m0_valid, b_m1_valid, b_m0_ready, b_m1_ready;
    logic [31:0] b_m0_addr, b_m1_addr, b_m0_wdata, b_m1_wdata;
    logic        b_m0_we, b_m1_we, b_m0_rvalid, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_m0_hit, b_m1_hit, b_c_req, b_c_we, b_c_hit, b_clr;
    logic [31:0] b_c_addr, b_c_wdata, b_c_rdata;
    logic [1:0]  b_req_cnt0, b_req_cnt1, b_hit_cnt0, b_hit_cnt1;

    cache_port_arbiter u_dut_a (
        .clk(clk), .reset(reset),
        .m0_valid(a_m0_valid), .m1_valid(a_m1_valid),
        .m0_ready(a_m0_ready), .m1_ready(a_m1_ready),
        .m0_addr(a_m0_addr), .m1_addr(a_m1_addr),
        .m0_wdata(a_m0_wdata), .m1_wdata(a_m1_wdata),
        .m0_we(a_m0_we), .m1_we(a_m1_we),
        .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid),
        .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata),
        .m0_hit(a_m0_hit), .m1_hit(a_m1_hit),
        .c_req(a_c_req), .c_addr(a_c_addr), .c_wdata(a_c_wdata), .c_we(a_c_we),
        .c_rdata(a_c_rdata), .c_hit(a_c_hit), .clr_stats(a_clr),
        .req_cnt0(a_req_cnt0), .req_cnt1(a_req_cnt1),
        .hit_cnt0(a_hit_cnt0), .hit_cnt1(a_hit_cnt1)
    );

    cache_port_arbiter #(.HIT_LAT(3), .MISS_LAT(0), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .m0_valid(b_m0_valid), .m1_valid(b_m1_valid),
        .m0_ready(b_m0_ready), .m1_ready(b_m1_ready),
        .m0_addr(b_m0_addr), .m1_addr(b_m1_addr),
        .m0_wdata(b_m0_wdata), .m1_wdata(b_m1_wdata),
        .m0_we(b_m0_we), .m1_we(b_m1_we),
        .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
        .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata),
        .m0_hit(b_m0_hit), .m1_hit(b_m1_hit),
        .c_req(b_c_req), .c_addr(b_c_addr), .c_wdata(b_c_wdata), .c_we(b_c_we),
        .c_rdata(b_c_rdata), .c_hit(b_c_hit), .clr_stats(b_clr),
        .req_cnt0(b_req_cnt0), .req_cnt1(b_req_cnt1),
        .hit_cnt0(b_hit_cnt0), .hit_cnt1(b_hit_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {a_m0_valid, a_m1_valid, a_m0_we, a_m1_we, a_c_hit, a_clr} = '0;
        {a_m0_addr, a_m1_addr, a_m0_wdata, a_m1_wdata, a_c_rdata} = '0;
        {b_m0_valid, b_m1_valid, b_m0_we, b_m1_we, b_c_hit, b_clr} = '0;
        {b_m0_addr, b_m1_addr, b_m0_wdata, b_m1_wdata, b_c_rdata} = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_m0_ready", 64'(a_m0_ready), 64'(0));
        chk("rst_rvalid", 64'({a_m0_rvalid, a_m1_rvalid}), 64'(0));
        chk("rst_c_req", 64'(a_c_req), 64'(0));
        chk("rst_c_addr", 64'(a_c_addr), 64'(0));
        chk("rst_req_cnt0", 64'(a_req_cnt0), 64'(0));

        // m0 read miss at 0x10: rvalid seven cycles after accept
        a_m0_valid = 1'b1; a_m0_addr = 32'h10; a_m0_we = 1'b0;
        #1;
        chk("miss_m0_ready", 64'(a_m0_ready), 64'(1));
        chk("miss_m1_ready", 64'(a_m1_ready), 64'(0));
        step();
        a_m0_valid = 1'b0;
        #1;
        chk("miss_c_req_t1", 64'(a_c_req), 64'(1));
        chk("miss_c_addr", 64'(a_c_addr), 64'h10);
        step();
        a_c_hit = 1'b0; a_c_rdata = 32'h10;
        #1;
        chk("miss_c_req_t2", 64'(a_c_req), 64'(0));
        for (int k = 3; k <= 6; k++) begin
            step();
            chk($sformatf("miss_no_rvalid_t%0d", k), 64'(a_m0_rvalid), 64'(0));
        end
        step();
        chk("miss_rvalid_t7", 64'(a_m0_rvalid), 64'(1));
        chk("miss_rdata", 64'(a_m0_rdata), 64'h10);
        chk("miss_hit", 64'(a_m0_hit), 64'(0));
        chk("miss_ready_in_resp", 64'(a_m0_ready), 64'(0));
        step();
        chk("miss_req_cnt0", 64'(a_req_cnt0), 64'(1));
        chk("miss_hit_cnt0", 64'(a_hit_cnt0), 64'(0));
        chk("miss_rvalid_after", 64'(a_m0_rvalid), 64'(0));

        // tie after reset: m0 first, then m1, then m0 again
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_m0_valid = 1'b1; a_m0_addr = 32'h100;
        a_m1_valid = 1'b1; a_m1_addr = 32'h200;
        a_c_hit = 1'b1; a_c_rdata = 32'h77;
        #1;
        chk("tie1_m0_ready", 64'(a_m0_ready), 64'(1));
        chk("tie1_m1_ready", 64'(a_m1_ready), 64'(0));
        step();
        a_m0_valid = 1'b0;
        #1;
        chk("tie1_c_addr", 64'(a_c_addr), 64'h100);
        chk("tie1_m1_wait", 64'(a_m1_ready), 64'(0));
        step();
        step();
        chk("tie1_m0_rvalid", 64'(a_m0_rvalid), 64'(1));
        chk("tie1_m1_ready_resp", 64'(a_m1_ready), 64'(0));
        step();
        a_m0_valid = 1'b1; a_m0_addr = 32'h104;
        #1;
        chk("tie2_m1_ready", 64'(a_m1_ready), 64'(1));
        chk("tie2_m0_ready", 64'(a_m0_ready), 64'(0));
        step();
        a_m1_addr = 32'h204;
        #1;
        chk("tie2_c_addr", 64'(a_c_addr), 64'h200);
        step();
        step();
        chk("tie2_m1_rvalid", 64'(a_m1_rvalid), 64'(1));
        chk("tie2_m1_rdata", 64'(a_m1_rdata), 64'h77);
        chk("tie2_m1_hit", 64'(a_m1_hit), 64'(1));
        chk("tie2_m0_rvalid", 64'(a_m0_rvalid), 64'(0));
        step();
        chk("tie3_m0_ready", 64'(a_m0_ready), 64'(1));
        chk("tie3_m1_ready", 64'(a_m1_ready), 64'(0));
        a_m0_valid = 1'b0; a_m1_valid = 1'b0;
        step();

        // four back-to-back m1 write hits, one every four cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_c_hit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_m1_valid = 1'b1; a_m1_we = 1'b1;
            a_m1_addr = 32'h40 + 32'(i * 4); a_m1_wdata = 32'hA0 + 32'(i);
            #1;
            chk($sformatf("wr%0d_m1_ready", i), 64'(a_m1_ready), 64'(1));
            step();
            a_m1_valid = 1'b0;
            #1;
            chk($sformatf("wr%0d_c_wdata", i), 64'(a_c_wdata), 64'(32'hA0 + 32'(i)));
            chk($sformatf("wr%0d_c_we", i), 64'(a_c_we), 64'(1));
            step();
            step();
            chk($sformatf("wr%0d_m1_rvalid", i), 64'(a_m1_rvalid), 64'(1));
            chk($sformatf("wr%0d_m0_quiet", i), 64'({a_m0_rvalid, a_m0_hit, a_m0_rdata}), 64'(0));
            step();
        end
        chk("wr_hit_cnt1", 64'(a_hit_cnt1), 64'(4));
        chk("wr_req_cnt1", 64'(a_req_cnt1), 64'(4));
        chk("wr_req_cnt0", 64'(a_req_cnt0), 64'(0));

        // reset during STALL drops the request
        a_m1_we = 1'b0; a_c_hit = 1'b0;
        a_m0_valid = 1'b1; a_m0_addr = 32'h80;
        step();
        a_m0_valid = 1'b0;
        step();
        step();
        chk("stall_no_rvalid", 64'(a_m0_rvalid), 64'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_c_addr", 64'(a_c_addr), 64'(0));
        chk("rst2_c_req", 64'(a_c_req), 64'(0));
        chk("rst2_cnts", 64'({a_req_cnt0, a_req_cnt1, a_hit_cnt1}), 64'(0));
        chk("rst2_rvalid", 64'({a_m0_rvalid, a_m1_rvalid}), 64'(0));
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("rst2_drop_%0d", k), 64'(a_m0_rvalid), 64'(0));
        end
        a_c_hit = 1'b1; a_c_rdata = 32'hABCD;
        a_m1_valid = 1'b1; a_m1_addr = 32'h90;
        #1;
        chk("post_m1_ready", 64'(a_m1_ready), 64'(1));
        step();
        a_m1_valid = 1'b0;
        step();
        step();
        chk("post_m1_rvalid", 64'(a_m1_rvalid), 64'(1));
        chk("post_m1_rdata", 64'(a_m1_rdata), 64'hABCD);
        step();

        // HIT_LAT=3, MISS_LAT=0: miss responds at t+5 with no stall
        b_m1_valid = 1'b1; b_m1_addr = 32'h300; b_c_hit = 1'b0; b_c_rdata = 32'h55;
        #1;
        chk("b_miss_ready", 64'(b_m1_ready), 64'(1));
        step();
        b_m1_valid = 1'b0;
        #1;
        chk("b_miss_c_req", 64'(b_c_req), 64'(1));
        step();
        step();
        step();
        chk("b_miss_no_rvalid_t4", 64'(b_m1_rvalid), 64'(0));
        step();
        chk("b_miss_rvalid_t5", 64'(b_m1_rvalid), 64'(1));
        chk("b_miss_hit", 64'(b_m1_hit), 64'(0));
        chk("b_miss_rdata", 64'(b_m1_rdata), 64'h55);
        step();
        chk("b_miss_done", 64'(b_m1_rvalid), 64'(0));

        // CNT_W=2 saturation, then clear racing an accept
        b_c_hit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_m0_valid = 1'b1; b_m0_addr = 32'h400 + 32'(i);
            #1;
            chk($sformatf("b_sat%0d_ready", i), 64'(b_m0_ready), 64'(1));
            step();
            b_m0_valid = 1'b0;
            repeat (4) step();
            chk($sformatf("b_sat%0d_rvalid", i), 64'(b_m0_rvalid), 64'(1));
            step();
        end
        chk("b_sat_hit_cnt0", 64'(b_hit_cnt0), 64'(3));
        chk("b_sat_req_cnt0", 64'(b_req_cnt0), 64'(3));
        b_m0_valid = 1'b1; b_clr = 1'b1;
        step();
        b_m0_valid = 1'b0; b_clr = 1'b0;
        #1;
        chk("b_clr_req_cnt0", 64'(b_req_cnt0), 64'(0));
        chk("b_clr_hit_cnt0", 64'(b_hit_cnt0), 64'(0));
        chk("b_clr_c_req", 64'(b_c_req), 64'(1));
        repeat (4) step();
        chk("b_clr_rvalid", 64'(b_m0_rvalid), 64'(1));
        step();
        chk("b_clr_hit_cnt0_after", 64'(b_hit_cnt0), 64'(1));
        chk("b_clr_req_cnt0_after", 64'(b_req_cnt0), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester front end for the cache model: it arbitrates between an instruction-side port (m0) and a data-side port (m1), presents one request at a time to the shared cache, and models hit/miss latency. It returns each response to the originating port and keeps per-port request and hit counters for hit-rate reporting. It sits between the requester bench/CPU model and the cache's address/data/mode inputs.

## Interface
- AW, 32, address width
- DW, 32, data width
- HIT_LAT, 1, cycles from c_req to valid c_rdata/c_hit; must be ≥1
- MISS_LAT, 4, extra stall cycles added on a miss; 0 means no stall
- CNT_W, 16, statistics counter width
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset; synchronous, active-high
- m0_valid, m1_valid  in  1  request pending on port 0 / port 1
- m0_ready, m1_ready  out  1  request accepted this cycle
- m0_addr, m1_addr  in  AW  request address
- m0_wdata, m1_wdata  in  DW  write data
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_rvalid, m1_rvalid  out  1  one-cycle response strobe
- m0_rdata, m1_rdata  out  DW  response data; valid while rvalid is high
- m0_hit, m1_hit  out  1  cache hit flag; valid while rvalid is high
- c_req  out  1  one-cycle request strobe to the cache
- c_addr, c_wdata, c_we  out  AW/DW/1  held request fields to the cache
- c_rdata  in  DW  cache read data
- c_hit  in  1  cache hit flag
- clr_stats  in  1  synchronous clear of all counters
- req_cnt0, req_cnt1, hit_cnt0, hit_cnt1  out  CNT_W  per-port statistics

## Operation
- FSM states: IDLE, ISSUE, WAIT, STALL, RESP.
- IDLE:
  - mX_ready is combinational, high only for the granted port while in IDLE.
  - Only one valid → grant that port. Both valid → grant the port not granted last (round-robin bit).
  - The round-robin bit resets so that m0 wins the first tie.
  - On accept (valid&&ready): latch addr/wdata/we and the port id into c_addr/c_wdata/c_we, update the round-robin bit, increment req_cntX, go to ISSUE.
- ISSUE: c_req=1 for exactly one cycle; go to WAIT.
- WAIT: a down-counter runs HIT_LAT cycles. In the final WAIT cycle, sample c_rdata and c_hit.
  - Hit, or MISS_LAT=0 → go to RESP.
  - Otherwise → go to STALL.
- STALL: lasts MISS_LAT cycles, then go to RESP.
- RESP:
  - The granted port gets mX_rvalid=1 with the sampled rdata and hit.
  - hit_cntX increments if the sampled hit=1.
  - Go to IDLE.
- Writes follow the same path. rdata returns the sampled c_rdata.
- c_addr/c_wdata/c_we stay stable from ISSUE through RESP and keep their values while in IDLE.
- Counters saturate at all-ones.
- clr_stats zeroes all four counters. If clr_stats coincides with an increment, the clear wins.
- Reset behaviour:
  - State returns to IDLE.
  - All outputs go to 0: ready, rvalid, rdata, hit, c_*, counters.
  - Round-robin bit set so m0 is preferred.
  - An in-flight request is dropped with no rvalid.

## Timing
- Accept at cycle t; c_req at t+1; c_rdata/c_hit sampled at t+1+HIT_LAT.
- rvalid timing:
  - Hit: rvalid at t+2+HIT_LAT (t+3 with defaults).
  - Miss: rvalid at t+2+HIT_LAT+MISS_LAT (t+7 with defaults).
- Next accept is no earlier than the cycle after RESP. Peak throughput with defaults is one hit per 4 cycles.
- Requests arriving while not in IDLE see ready=0 and must hold valid and fields until accepted.
- rvalid never coincides with ready on the same port.

## Test plan
- m0 read addr 0x10, c_hit=0, c_rdata=0x10 at t+2 → c_req at t+1 only; m0_rvalid at t+7, m0_rdata=0x10, m0_hit=0; req_cnt0=1, hit_cnt0=0.
- m0 and m1 valid together right after reset → m0 accepted first; m1 accepted in the IDLE cycle after m0 RESP; next tie grants m0.
- Four back-to-back m1 writes, c_hit=1 → m1_rvalid at t+3, t+7, t+11, t+15; hit_cnt1=4; m0 outputs stay 0.
- reset asserted during STALL → no rvalid; all outputs 0 the next cycle; a following m1 read completes with normal latency.
- CNT_W=2, five m0 hits → hit_cnt0=3 (saturated); clr_stats in the same cycle as a new accept → req_cnt0=0 next cycle.
- MISS_LAT=0, HIT_LAT=3, m1 miss → rvalid at t+5, m1_hit=0, no STALL cycle.
